// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  // Memory-port FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Which requester owns the in-flight memory access
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

  // Consecutive data grants tolerated while fetch is waiting
  localparam int unsigned DEFAULT_MAX_DM_STREAK = 4;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter shared by the fetch and memory stages.
// Data accesses win over fetch, but a streak limit keeps fetch from starving.
// Each access: grant in IDLE, wait for mem_ack in BUSY, one-cycle ready in RESP.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_DM_STREAK = DEFAULT_MAX_DM_STREAK
) (
  input  logic                    clk,
  input  logic                    rst,
  // fetch port
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  // data port
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  output logic                    dm_ready,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  // backing memory port
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  // pipeline stalls
  output logic                    stall_f,
  output logic                    stall_m
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);

  arb_state_e              state_q, state_d;
  grant_e                  gnt_q, gnt_d;
  logic [STREAK_W-1:0]     streak_q, streak_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;
  logic                    if_ready_q, if_ready_d;
  logic                    dm_ready_q, dm_ready_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   dm_rdata_q, dm_rdata_d;

  logic                    streak_max;
  logic                    dm_wins;

  assign streak_max = (streak_q == STREAK_W'(MAX_DM_STREAK));
  // Data has priority unless fetch has already been passed over too often
  assign dm_wins    = dm_req && !(if_req && streak_max);

  // Next-state, grant, request-field and response logic
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dm_wins) begin
          state_d     = BUSY;
          gnt_d       = GNT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
          if (!if_req) begin
            streak_d = '0;
          end else if (!streak_max) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (if_req) begin
          state_d     = BUSY;
          gnt_d       = GNT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          streak_d    = '0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (gnt_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ready_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_f   = if_req & ~if_ready_q;
  assign stall_m   = dm_req & ~dm_ready_q;

endmodule
